// File: rtl/jesd204_rx_ilas_pkg.sv
// Shared constants, FSM encoding and sizing helper for the JESD204 RX ILAS capture stage.
package jesd204_rx_ilas_pkg;

    localparam logic [7:0] K28_0_R = 8'h1C;
    localparam logic [7:0] K28_3_A = 8'h7C;
    localparam logic [7:0] K28_4_Q = 8'h9C;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_R2,
        CAPTURE,
        WAIT_END,
        DONE,
        ERROR
    } ilas_state_t;

    // The 16-octet configuration image spans this many beats of the data path.
    function automatic int ilas_data_length(input int dpw);
        return (dpw == 4) ? 4 : 2;
    endfunction

endpackage

// File: rtl/jesd204_rx_ilas_fchk.sv
// Octet-masked mod-256 accumulator; compares the running sum with the top octet on the last word.
module jesd204_rx_ilas_fchk #(
    parameter int DATA_PATH_WIDTH = 4
) (
    input  logic                           core_clk,
    input  logic                           core_reset,
    input  logic [DATA_PATH_WIDTH*8-1:0]   data,
    input  logic [DATA_PATH_WIDTH-1:0]     mask,
    input  logic                           clear,
    input  logic                           enable,
    input  logic                           last,
    output logic                           match
);

    logic [7:0] acc;
    logic [7:0] sum;

    always_comb begin
        sum = acc;
        for (int i = 0; i < DATA_PATH_WIDTH; i++) begin
            if (mask[i]) begin
                sum = sum + data[i*8 +: 8];
            end
        end
        match = last && (sum == data[DATA_PATH_WIDTH*8-1 -: 8]);
    end

    always_ff @(posedge core_clk) begin
        if (core_reset || clear) begin
            acc <= 8'h00;
        end else if (enable) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/jesd204_rx_ilas_capture.sv
// Per-lane ILAS follower: tracks the multiframe sequence, writes the second multiframe's
// configuration image to the ILAS memory and reports completion or a sticky error.
module jesd204_rx_ilas_capture
    import jesd204_rx_ilas_pkg::*;
#(
    parameter int DATA_PATH_WIDTH  = 4,
    parameter int ILAS_MULTIFRAMES = 4
) (
    input  logic                           core_clk,
    input  logic                           core_reset,
    input  logic                           core_start,
    input  logic [DATA_PATH_WIDTH*8-1:0]   core_data,
    input  logic [DATA_PATH_WIDTH-1:0]     core_charisk,
    output logic                           core_ilas_config_valid,
    output logic [1:0]                     core_ilas_config_addr,
    output logic [DATA_PATH_WIDTH*8-1:0]   core_ilas_config_data,
    output logic                           core_ilas_done,
    output logic                           core_ilas_error,
    output logic                           core_ilas_active
);

    localparam int         DPW       = DATA_PATH_WIDTH;
    localparam int         DW        = DPW * 8;
    localparam int         ILAS_LEN  = ilas_data_length(DPW);
    localparam logic [1:0] LAST_WORD = 2'(ILAS_LEN - 1);
    localparam logic [7:0] MF_TARGET = 8'(ILAS_MULTIFRAMES);

    ilas_state_t state, state_n;
    logic [7:0]  mf_cnt, mf_cnt_n;
    logic [1:0]  word_idx, word_n;
    logic        cap_err, cap_err_n;
    logic        at_boundary, boundary_n;
    logic        wr_valid_n;

    logic           oct0_is_r, oct1_is_q, last_is_a, bad_k;
    logic           fchk_clear, fchk_en, fchk_last, fchk_match;
    logic [DPW-1:0] fchk_mask;

    always_comb begin
        oct0_is_r = core_charisk[0] && (core_data[7:0] == K28_0_R);
        oct1_is_q = core_charisk[1] && (core_data[15:8] == K28_4_Q);
        last_is_a = core_charisk[DPW-1] && (core_data[DW-1 -: 8] == K28_3_A);
        bad_k     = 1'b0;
        // Only /A/ closing a beat, or /R/ opening the beat after an /A/, may carry a K flag.
        for (int i = 0; i < DPW; i++) begin
            if (core_charisk[i] &&
                !((i == DPW - 1) && (core_data[i*8 +: 8] == K28_3_A)) &&
                !((i == 0) && (core_data[7:0] == K28_0_R) && at_boundary)) begin
                bad_k = 1'b1;
            end
        end
    end

    always_comb begin
        state_n    = state;
        mf_cnt_n   = mf_cnt;
        word_n     = word_idx;
        cap_err_n  = cap_err;
        boundary_n = at_boundary;
        wr_valid_n = 1'b0;
        fchk_clear = 1'b0;
        fchk_en    = 1'b0;
        fchk_last  = 1'b0;
        fchk_mask  = '0;
        if (core_start) begin
            fchk_clear = 1'b1;
            cap_err_n  = 1'b0;
            word_n     = 2'd0;
            boundary_n = last_is_a;
            mf_cnt_n   = last_is_a ? 8'd1 : 8'd0;
            state_n    = oct0_is_r ? WAIT_R2 : ERROR;
        end else begin
            case (state)
                WAIT_R2: begin
                    if (mf_cnt != 8'd0) begin
                        if (oct0_is_r && oct1_is_q) begin
                            wr_valid_n = 1'b1;
                            fchk_en    = 1'b1;
                            fchk_mask  = {{(DPW-2){1'b1}}, 2'b00};
                            cap_err_n  = |core_charisk[DPW-1:2];
                            word_n     = 2'd1;
                            state_n    = CAPTURE;
                        end else begin
                            state_n = ERROR;
                        end
                    end else if (last_is_a) begin
                        mf_cnt_n = mf_cnt + 8'd1;
                    end
                end
                CAPTURE: begin
                    wr_valid_n = 1'b1;
                    fchk_en    = 1'b1;
                    cap_err_n  = cap_err || (|core_charisk);
                    if (word_idx == LAST_WORD) begin
                        fchk_mask  = {1'b0, {(DPW-1){1'b1}}};
                        fchk_last  = 1'b1;
                        boundary_n = 1'b0;
                        state_n    = (cap_err_n || !fchk_match) ? ERROR : WAIT_END;
                    end else begin
                        fchk_mask = '1;
                        word_n    = word_idx + 2'd1;
                    end
                end
                WAIT_END: begin
                    boundary_n = last_is_a;
                    if (bad_k) begin
                        state_n = ERROR;
                    end else if (last_is_a) begin
                        mf_cnt_n = mf_cnt + 8'd1;
                        if (mf_cnt_n == MF_TARGET) begin
                            state_n = DONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge core_clk) begin
        if (core_reset) begin
            state                  <= IDLE;
            mf_cnt                 <= 8'd0;
            word_idx               <= 2'd0;
            cap_err                <= 1'b0;
            at_boundary            <= 1'b0;
            core_ilas_config_valid <= 1'b0;
            core_ilas_config_addr  <= 2'd0;
            core_ilas_config_data  <= '0;
        end else begin
            state                  <= state_n;
            mf_cnt                 <= mf_cnt_n;
            word_idx               <= word_n;
            cap_err                <= cap_err_n;
            at_boundary            <= boundary_n;
            core_ilas_config_valid <= wr_valid_n;
            if (wr_valid_n) begin
                core_ilas_config_addr <= word_idx;
                core_ilas_config_data <= core_data;
            end
        end
    end

    assign core_ilas_done   = (state == DONE);
    assign core_ilas_error  = (state == ERROR);
    assign core_ilas_active = (state == WAIT_R2) || (state == CAPTURE) || (state == WAIT_END);

    jesd204_rx_ilas_fchk #(
        .DATA_PATH_WIDTH(DPW)
    ) u_fchk (
        .core_clk  (core_clk),
        .core_reset(core_reset),
        .data      (core_data),
        .mask      (fchk_mask),
        .clear     (fchk_clear),
        .enable    (fchk_en),
        .last      (fchk_last),
        .match     (fchk_match)
    );

endmodule

// File: tb/tb_jesd204_rx_ilas_capture.sv
// Directed-sequence bench with randomized ILAS payloads for both data path widths,
// checked against an octet-level model of the configuration image.
module tb_jesd204_rx_ilas_capture;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start4, start8;
    logic [31:0] data4;
    logic [3:0]  k4;
    logic [63:0] data8;
    logic [7:0]  k8;

    logic        v4, done4, err4, act4;
    logic [1:0]  a4;
    logic [31:0] d4;
    logic        v8, done8, err8, act8;
    logic [1:0]  a8;
    logic [63:0] d8;

    jesd204_rx_ilas_capture #(.DATA_PATH_WIDTH(4), .ILAS_MULTIFRAMES(4)) dut4 (
        .core_clk(clk), .core_reset(rst), .core_start(start4),
        .core_data(data4), .core_charisk(k4),
        .core_ilas_config_valid(v4), .core_ilas_config_addr(a4),
        .core_ilas_config_data(d4), .core_ilas_done(done4),
        .core_ilas_error(err4), .core_ilas_active(act4)
    );

    jesd204_rx_ilas_capture #(.DATA_PATH_WIDTH(8), .ILAS_MULTIFRAMES(4)) dut8 (
        .core_clk(clk), .core_reset(rst), .core_start(start8),
        .core_data(data8), .core_charisk(k8),
        .core_ilas_config_valid(v8), .core_ilas_config_addr(a8),
        .core_ilas_config_data(d8), .core_ilas_done(done8),
        .core_ilas_error(err8), .core_ilas_active(act8)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // One ILAS sequence: 4 multiframes of 32 octets.
    logic [7:0] oct [0:127];
    bit         kf  [0:127];

    logic [63:0] got_data[$];
    logic [1:0]  got_addr[$];
    int          got_cyc[$];
    logic [63:0] exp_data[$];
    logic [1:0]  exp_addr[$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (v4) begin
            got_data.push_back({32'h0, d4});
            got_addr.push_back(a4);
            got_cyc.push_back(cyc);
        end
        if (v8) begin
            got_data.push_back(d8);
            got_addr.push_back(a8);
            got_cyc.push_back(cyc);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Random payload; config octets 2..14 sum to 0x5A and FCHK = 0x5A + delta.
    task automatic buildIlas(input logic [7:0] delta);
        logic [7:0] sum;
        for (int i = 0; i < 128; i++) begin
            oct[i] = 8'($urandom);
            kf[i]  = 1'b0;
        end
        for (int mf = 0; mf < 4; mf++) begin
            oct[mf*32]      = 8'h1C; kf[mf*32]      = 1'b1;
            oct[mf*32 + 31] = 8'h7C; kf[mf*32 + 31] = 1'b1;
        end
        oct[33] = 8'h9C; kf[33] = 1'b1;
        sum = 8'h00;
        for (int i = 34; i < 46; i++) sum = sum + oct[i];
        oct[46] = 8'h5A - sum;
        oct[47] = 8'h5A + delta;
    endtask

    function automatic bit fchkOk();
        logic [7:0] s = 8'h00;
        for (int i = 34; i <= 46; i++) s = s + oct[i];
        return s == oct[47];
    endfunction

    task automatic expectImage(input int dpw, input int nwords);
        logic [63:0] w;
        for (int n = 0; n < nwords; n++) begin
            w = 64'h0;
            for (int j = 0; j < dpw; j++) w[j*8 +: 8] = oct[32 + n*dpw + j];
            exp_data.push_back(w);
            exp_addr.push_back(2'(n));
        end
    endtask

    task automatic applyStimulus(input int dpw, input int first, input int last, input bit with_start);
        for (int b = first; b <= last; b++) begin
            @(negedge clk);
            start4 = 1'b0;
            start8 = 1'b0;
            if (dpw == 4) begin
                for (int j = 0; j < 4; j++) begin
                    data4[j*8 +: 8] = oct[b*4 + j];
                    k4[j]           = kf[b*4 + j];
                end
                start4 = with_start && (b == first);
            end else begin
                for (int j = 0; j < 8; j++) begin
                    data8[j*8 +: 8] = oct[b*8 + j];
                    k8[j]           = kf[b*8 + j];
                end
                start8 = with_start && (b == first);
            end
        end
    endtask

    task automatic applyIdle(input int n);
        repeat (n) begin
            @(negedge clk);
            start4 = 1'b0; start8 = 1'b0;
            data4  = '0;   k4     = '0;
            data8  = '0;   k8     = '0;
        end
    endtask

    task automatic checkWrites(input string tag);
        checkOutput($sformatf("%s_count", tag), 64'(got_data.size()), 64'(exp_data.size()));
        for (int i = 0; i < exp_data.size(); i++) begin
            if (i < got_data.size()) begin
                checkOutput($sformatf("%s_addr%0d", tag, i), 64'(got_addr[i]), 64'(exp_addr[i]));
                checkOutput($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
            end
        end
        got_data.delete(); got_addr.delete(); got_cyc.delete();
        exp_data.delete(); exp_addr.delete();
    endtask

    initial begin
        int diff;
        rst = 1'b1;
        applyIdle(3);
        checkOutput("reset_dut4", {26'h0, v4, a4, d4, done4, err4, act4}, 64'h0);
        checkOutput("reset_dut8", {v8, a8, d8[57:0], done8, err8, act8}, 64'h0);
        rst = 1'b0;
        applyIdle(2);
        got_data.delete(); got_addr.delete(); got_cyc.delete();

        $display("[TB] DPW=4 well-formed ILAS");
        buildIlas(8'h00);
        expectImage(4, 4);
        applyStimulus(4, 0, 31, 1'b1);
        checkOutput("dpw4_done_early", 64'(done4), 64'(0));
        checkOutput("dpw4_active_mid", 64'(act4), 64'(1));
        applyIdle(1);
        checkOutput("dpw4_done", 64'(done4), 64'(1));
        checkOutput("dpw4_error", 64'(err4), 64'(!fchkOk()));
        checkOutput("dpw4_active_end", 64'(act4), 64'(0));
        applyIdle(2);
        checkOutput("dpw4_word0_rq", 64'((got_data.size() > 0) ? got_data[0][15:0] : 16'h0), 64'h9C1C);
        checkWrites("dpw4_good");

        $display("[TB] DPW=8 well-formed ILAS");
        buildIlas(8'h00);
        expectImage(8, 2);
        applyStimulus(8, 0, 15, 1'b1);
        checkOutput("dpw8_done_early", 64'(done8), 64'(0));
        applyIdle(1);
        checkOutput("dpw8_done", 64'(done8), 64'(1));
        checkOutput("dpw8_error", 64'(err8), 64'(0));
        applyIdle(2);
        diff = (got_cyc.size() >= 2) ? (got_cyc[1] - got_cyc[0]) : -1;
        checkOutput("dpw8_consecutive", 64'(diff), 64'(1));
        checkWrites("dpw8_good");

        $display("[TB] DPW=4 corrupted FCHK");
        buildIlas(8'h01);
        expectImage(4, 4);
        applyStimulus(4, 0, 31, 1'b1);
        applyIdle(3);
        checkOutput("fchk_error", 64'(err4), 64'(!fchkOk()));
        checkOutput("fchk_done", 64'(done4), 64'(0));
        checkWrites("fchk_bad");

        $display("[TB] DPW=4 missing /Q/");
        buildIlas(8'h00);
        oct[33] = 8'hBC; kf[33] = 1'b1;
        applyStimulus(4, 0, 8, 1'b1);
        checkOutput("noq_error_early", 64'(err4), 64'(0));
        applyIdle(1);
        checkOutput("noq_error", 64'(err4), 64'(1));
        checkOutput("noq_active", 64'(act4), 64'(0));
        applyIdle(2);
        checkWrites("noq");

        $display("[TB] DPW=4 restart during capture");
        buildIlas(8'h00);
        expectImage(4, 2);
        applyStimulus(4, 0, 9, 1'b1);
        buildIlas(8'h00);
        expectImage(4, 4);
        applyStimulus(4, 0, 31, 1'b1);
        applyIdle(3);
        checkOutput("restart_done", 64'(done4), 64'(1));
        checkOutput("restart_error", 64'(err4), 64'(0));
        checkWrites("restart");

        $display("[TB] DPW=4 reset during capture");
        buildIlas(8'h00);
        expectImage(4, 2);
        applyStimulus(4, 0, 9, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_valid", 64'(v4), 64'(0));
        checkOutput("rst_flags", 64'({done4, err4, act4}), 64'(0));
        applyStimulus(4, 11, 20, 1'b0);
        applyIdle(2);
        checkOutput("rst_flags_after", 64'({done4, err4, act4}), 64'(0));
        checkWrites("rst_mid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
